cla48_mp_sequencer: RTL and testbench

//  Multi-precision add/subtract controller that time-multiplexes one cla_48bit

---
 rtl/cla48_mp_sequencer.sv | 159 +++++++++++++++
 tb/tb_cla48_mp_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla48_mp_sequencer.sv
// Multi-precision add/subtract sequencer: one 48-bit carry-lookahead adder walked over NWORDS limbs.
// Optional macro MPSEQ_OVF_EN adds the o_ovf two's-complement overflow output.

module cla_48bit (
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        c_in,
  output logic [47:0] sum,
  output logic        c_out
);

  // 4-bit lookahead groups; group carries chained across the 12 groups.
  function automatic logic [48:0] cla_add(input logic [47:0] x, input logic [47:0] y,
                                          input logic ci);
    logic [47:0] g;
    logic [47:0] p;
    logic [47:0] c;
    logic [12:0] gc;
    logic        gg;
    logic        pp;
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    gc = '0;
    gc[0] = ci;
    for (int k = 0; k < 12; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gc[k+1] = gg | (pp & gc[k]);
    end
    return {gc[12], p ^ c};
  endfunction

  assign {c_out, sum} = cla_add(a, b, c_in);

endmodule

module cla48_mp_sequencer #(
  parameter int NWORDS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_op_sub,
  input  logic                 i_cin,
  input  logic [NWORDS*48-1:0] i_a,
  input  logic [NWORDS*48-1:0] i_b,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [NWORDS*48-1:0] o_sum,
  output logic                 o_cout,
  output logic                 o_busy
`ifdef MPSEQ_OVF_EN
  ,
  output logic                 o_ovf
`endif
);

  localparam int W  = NWORDS * 48;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;
  logic [IW-1:0] idx;
  logic [47:0]   limb_a;
  logic [47:0]   limb_b;
  logic [47:0]   limb_sum;
  logic          limb_cout;

  assign limb_a = a_q[idx*48 +: 48];
  assign limb_b = b_q[idx*48 +: 48];

  cla_48bit u_cla (
    .a    (limb_a),
    .b    (limb_b),
    .c_in (carry_q),
    .sum  (limb_sum),
    .c_out(limb_cout)
  );

`ifdef MPSEQ_OVF_EN
  logic ovf_q;
`endif

  // B is stored pre-inverted for subtract so RUN never needs to know the op.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MPSEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            a_q     <= i_a;
            b_q     <= i_op_sub ? ~i_b : i_b;
            carry_q <= i_op_sub ? 1'b1 : i_cin;
            idx     <= '0;
            sum_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*48 +: 48] <= limb_sum;
          carry_q             <= limb_cout;
          if (idx == LAST) begin
            cout_q <= limb_cout;
`ifdef MPSEQ_OVF_EN
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (limb_sum[47] != a_q[W-1]);
`endif
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (i_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_rsp_valid = (state == DONE);
  assign o_sum       = sum_q;
  assign o_cout      = cout_q;
`ifdef MPSEQ_OVF_EN
  assign o_ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla48_mp_sequencer.sv
// Directed bench for cla48_mp_sequencer at NWORDS=2 (96-bit operands).
// Overflow vectors are exercised only when MPSEQ_OVF_EN is defined.

module tb_cla48_mp_sequencer;

  logic        clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_op_sub;
  logic        i_cin;
  logic [95:0] i_a;
  logic [95:0] i_b;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [95:0] o_sum;
  logic        o_cout;
  logic        o_busy;
`ifdef MPSEQ_OVF_EN
  logic        o_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [95:0] ONES = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  cla48_mp_sequencer #(.NWORDS(2)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_op_sub   (i_op_sub),
    .i_cin      (i_cin),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_sum      (o_sum),
    .o_cout     (o_cout),
    .o_busy     (o_busy)
`ifdef MPSEQ_OVF_EN
    ,
    .o_ovf      (o_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request, scrambles the request inputs after accept, and counts
  // edges until o_rsp_valid (21 means it never came).
  task automatic run_op(input logic sub, input logic cin, input logic [95:0] a,
                        input logic [95:0] b, output int lat, output logic busy_seen);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_op_sub    = sub;
    i_cin       = cin;
    i_a         = a;
    i_b         = b;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_op_sub    = ~sub;
    i_cin       = ~cin;
    i_a         = ~a;
    i_b         = ~b;
    busy_seen   = o_busy;
    lat         = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_rsp();
    @(negedge clk);
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rst       = 1'b1;
    i_req_valid = 1'b1;
    i_a         = 96'h1234;
    i_b         = 96'h5678;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", o_rsp_valid); end
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", o_req_ready); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    n_vec++; if (o_sum !== 96'h0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", o_sum); end
    n_vec++; if (o_cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", o_cout); end
`ifdef MPSEQ_OVF_EN
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
`endif
    @(negedge clk);
    i_rst       = 1'b0;
    i_req_valid = 1'b0;
  endtask

  task automatic test_add_carry();
    int   lat;
    logic bsy;
    run_op(1'b0, 1'b0, 96'h0000_0000_0000_FFFF_FFFF_FFFF, 96'h1, lat, bsy);
    n_vec++; if (bsy !== 1'b1) begin n_err++; $display("FAIL add_carry_busy got=%b exp=1", bsy); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_carry_latency got=%0d exp=2", lat); end
    n_vec++; if (o_sum !== 96'h0000_0000_0001_0000_0000_0000) begin n_err++; $display("FAIL add_carry_sum got=%h exp=000000000001000000000000", o_sum); end
    n_vec++; if (o_cout !== 1'b0) begin n_err++; $display("FAIL add_carry_cout got=%b exp=0", o_cout); end
    n_vec++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL add_carry_ready_in_done got=%b exp=0", o_req_ready); end
    release_rsp();
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_carry_valid_drop got=%b exp=0", o_rsp_valid); end
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL add_carry_ready_after got=%b exp=1", o_req_ready); end
  endtask

  task automatic test_sub_borrow();
    int   lat;
    logic bsy;
    run_op(1'b1, 1'b0, 96'h0, 96'h1, lat, bsy);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sub_borrow_latency got=%0d exp=2", lat); end
    n_vec++; if (o_sum !== ONES) begin n_err++; $display("FAIL sub_borrow_sum got=%h exp=%h", o_sum, ONES); end
    n_vec++; if (o_cout !== 1'b0) begin n_err++; $display("FAIL sub_borrow_cout got=%b exp=0", o_cout); end
    release_rsp();
    // cin must be ignored on subtract: 5 - 3 with cin=1 is still 2
    run_op(1'b1, 1'b1, 96'h5, 96'h3, lat, bsy);
    n_vec++; if (o_sum !== 96'h2) begin n_err++; $display("FAIL sub_small_sum got=%h exp=2", o_sum); end
    n_vec++; if (o_cout !== 1'b1) begin n_err++; $display("FAIL sub_small_cout got=%b exp=1", o_cout); end
    release_rsp();
    run_op(1'b1, 1'b0, 96'hABCD_0000_1111_2222_3333_4444, 96'hABCD_0000_1111_2222_3333_4444, lat, bsy);
    n_vec++; if (o_sum !== 96'h0) begin n_err++; $display("FAIL sub_equal_sum got=%h exp=0", o_sum); end
    n_vec++; if (o_cout !== 1'b1) begin n_err++; $display("FAIL sub_equal_cout got=%b exp=1", o_cout); end
    release_rsp();
  endtask

  task automatic test_add_ones();
    int   lat;
    logic bsy;
    run_op(1'b0, 1'b1, ONES, ONES, lat, bsy);
    n_vec++; if (o_sum !== ONES) begin n_err++; $display("FAIL add_ones_sum got=%h exp=%h", o_sum, ONES); end
    n_vec++; if (o_cout !== 1'b1) begin n_err++; $display("FAIL add_ones_cout got=%b exp=1", o_cout); end
    release_rsp();
    run_op(1'b0, 1'b1, ONES, 96'h0, lat, bsy);
    n_vec++; if (o_sum !== 96'h0) begin n_err++; $display("FAIL add_cin_wrap_sum got=%h exp=0", o_sum); end
    n_vec++; if (o_cout !== 1'b1) begin n_err++; $display("FAIL add_cin_wrap_cout got=%b exp=1", o_cout); end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int   lat;
    logic bsy;
    run_op(1'b0, 1'b0, 96'd10, 96'd20, lat, bsy);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_op_sub    = 1'b0;
    i_cin       = 1'b0;
    i_a         = 96'd1;
    i_b         = 96'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++; if (o_rsp_valid !== 1'b1 || o_sum !== 96'd30 || o_req_ready !== 1'b0)
        begin n_err++; $display("FAIL bp_hold cyc=%0d got valid=%b sum=%h ready=%b exp valid=1 sum=1e ready=0", i, o_rsp_valid, o_sum, o_req_ready); end
    end
    release_rsp();
    n_vec++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      begin n_err++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", o_rsp_valid, o_req_ready); end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL bp_second_accept got busy=%b exp=1", o_busy); end
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) begin lat = i; break; end
    end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL bp_second_latency got=%0d exp=2", lat); end
    n_vec++; if (o_sum !== 96'd2) begin n_err++; $display("FAIL bp_second_sum got=%h exp=2", o_sum); end
    release_rsp();
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_op_sub    = 1'b0;
    i_cin       = 1'b0;
    i_a         = 96'd7;
    i_b         = 96'd8;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%b exp=0", o_rsp_valid); end
    n_vec++; if (o_sum !== 96'h0) begin n_err++; $display("FAIL abort_sum got=%h exp=0", o_sum); end
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", o_req_ready); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", o_busy); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_response got=%b exp=0", seen); end
  endtask

  // rsp_ready held high throughout: it must not shortcut RUN, and requests
  // held valid are taken one after another.
  task automatic test_back_to_back();
    int nrsp;
    int bad;
    @(negedge clk);
    i_rsp_ready = 1'b1;
    i_req_valid = 1'b1;
    i_op_sub    = 1'b0;
    i_cin       = 1'b1;
    i_a         = 96'h0000_0001_0000_FFFF_FFFF_FFFF;
    i_b         = 96'h0000_0002_0000_0000_0000_0000;
    nrsp = 0;
    bad  = 0;
    for (int i = 0; i < 30 && nrsp < 2; i++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) begin
        nrsp++;
        if (o_sum !== 96'h0000_0003_0001_0000_0000_0000) bad++;
      end
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    n_vec++; if (nrsp !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", nrsp); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_sum got %0d bad sums (last=%h) exp=000000030001000000000000", bad, o_sum); end
    repeat (3) @(posedge clk);
    #1;
  endtask

`ifdef MPSEQ_OVF_EN
  task automatic test_ovf();
    int   lat;
    logic bsy;
    run_op(1'b0, 1'b0, 96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'h1, lat, bsy);
    n_vec++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos_ovf got=%b exp=1", o_ovf); end
    n_vec++; if (o_sum !== 96'h8000_0000_0000_0000_0000_0000) begin n_err++; $display("FAIL ovf_pos_sum got=%h exp=800000000000000000000000", o_sum); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_held got=%b exp=1", o_ovf); end
    release_rsp();
    run_op(1'b1, 1'b0, 96'h5, 96'h3, lat, bsy);
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_sub_ovf got=%b exp=0", o_ovf); end
    n_vec++; if (o_sum !== 96'h2) begin n_err++; $display("FAIL ovf_sub_sum got=%h exp=2", o_sum); end
    n_vec++; if (o_cout !== 1'b1) begin n_err++; $display("FAIL ovf_sub_cout got=%b exp=1", o_cout); end
    release_rsp();
  endtask
`endif

  initial begin
    i_rst       = 1'b0;
    i_req_valid = 1'b0;
    i_op_sub    = 1'b0;
    i_cin       = 1'b0;
    i_a         = '0;
    i_b         = '0;
    i_rsp_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_add_ones();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef MPSEQ_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
